wb_scheduler: RTL and testbench
===============================

# wb_scheduler

Writeback scheduler between the execution units and the register file writeback port. It accepts result writes from NREQ requesters through valid/ready handshakes and buffers each requester in a small FIFO. It grants one write per iCLK_WB cycle, round-robin, and drives the register file's writeback index/value. A busy-bit scoreboard is set at issue and cleared at writeback; it stalls the allocate stage on RAW and WAW hazards.

## Interface
Parameters:
- NREQ, 2 — number of writeback requesters
- DW, 8 — data width
- NREGS, 4 — architectural registers (index width RW = 2)
- DEPTH, 2 — per-requester FIFO entries (power of two)

Ports:
- iRST  in  1  reset iRST, asynchronous, active-high
- iCLK_WB  in  1  clock iCLK_WB; every flop in the block runs on it
- iISSUE_VALID  in  1  allocate stage wants to issue an instruction
- iISSUE_DST  in  RW  destination register of the issuing instruction
- iISSUE_SRC1  in  RW  source 1 register index
- iISSUE_SRC2  in  RW  source 2 register index
- iISSUE_SRC2_IS_IMM  in  1  1 = source 2 is an immediate, so no hazard check on SRC2
- oSTALL  out  1  combinational; issue is blocked this cycle
- iREQ_VALID  in  NREQ  per-requester write request
- iREQ_IDX  in  NREQ*RW  packed destination indices; requester r occupies bits [r*RW +: RW]
- iREQ_VAL  in  NREQ*DW  packed write data; requester r occupies bits [r*DW +: DW]
- oREQ_READY  out  NREQ  per-requester; high when that FIFO is not full
- oWB_EN  out  1  registered; the writeback port is valid this cycle
- oNEXT_REG_IDX  out  RW  registered writeback index
- oNEXT_REG_VAL  out  DW  registered writeback value
- oBUSY  out  NREGS  scoreboard busy bits
- oERR  out  1  sticky; set when a writeback targets a register whose busy bit is 0

## Operation
Reset values:
- All outputs are 0, except oREQ_READY, which is all 1s.
- FIFOs are empty and the round-robin pointer selects requester 0.
- Reset asserted mid-operation flushes all buffered writes without emitting them and clears the scoreboard.

Requester side:
- A push occurs when iREQ_VALID[r] && oREQ_READY[r]. Data presented while ready is low is ignored; the requester must hold it.

Arbitration:
- Candidates are the non-empty FIFO heads.
- Search starts at the requester after the last granted one, wrapping modulo NREQ; the first candidate found wins.
- The winner's head is popped. Its idx/val are registered onto oNEXT_* with oWB_EN=1.
- With no candidates: oWB_EN=0, oNEXT_* hold their previous values, and the pointer does not change.

Scoreboard:
- Issue succeeds when iISSUE_VALID && !oSTALL. Success sets busy[iISSUE_DST].
- oSTALL = iISSUE_VALID && (busy[SRC1] || (!SRC2_IS_IMM && busy[SRC2]) || busy[DST]).
- A grant clears busy[idx].
- The stall check uses current busy bits only, with no bypass. A register being cleared this cycle still stalls; issue proceeds the following cycle.
- Set and clear of the same register in the same cycle cannot occur, because issue requires busy=0 and a legal clear requires busy=1. If it does occur, set wins.
- A grant to a non-busy register still writes, and sets oERR.

## Timing
- Push at edge N: the entry becomes eligible in cycle N+1. oWB_EN/oNEXT_* and the busy clear take effect after edge N+1. There is no FIFO fall-through.
- A full FIFO that is popped in cycle N raises ready after edge N. There is no same-cycle push-on-pop when full.
- Throughput is one writeback per cycle in aggregate. With all requesters continuously backlogged, each one is granted at least every NREQ cycles.
- oSTALL is combinational from the issue inputs and the busy flops. It is not registered.

## Structure
- Package wb_pkg holds DW, NREGS, RW, NREQ, the typedef reg_idx_t (logic [RW-1:0]) and the typedef wb_entry_t {reg_idx_t idx; logic [DW-1:0] val}.
- Sub-module wb_fifo: DEPTH-entry synchronous FIFO of wb_entry_t with push/pop/full/empty. It is instantiated NREQ times.
- The arbiter and scoreboard live in the top module.

## Test plan
- Reset, then issue DST=1 SRC1=0 SRC2=imm -> no stall, oBUSY=4'b0010. Issue SRC1=1 next cycle -> oSTALL=1.
- Requester 0 writes idx1 val 8'd42 at edge N -> oWB_EN=1, idx=1, val=42 after edge N+1; oBUSY=0; the stalled issue proceeds the following cycle.
- Both requesters push 2 entries each in back-to-back cycles -> grants alternate r0,r1,r0,r1 on 4 consecutive cycles; oREQ_READY drops to 0 for a requester when its FIFO holds 2 entries.
- Requester 1 holds valid while full -> no data lost or duplicated; all values appear exactly once, in order per requester.
- Writeback to a non-busy register -> oERR=1 and stays 1 until reset.
- Assert iRST with 3 buffered entries and busy=4'b1011 -> outputs zero immediately; no writeback occurs after deassertion.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback scheduler.
// Entries carry a destination index plus write data.
package wb_pkg;

  localparam int NREQ  = 2;
  localparam int DW    = 8;
  localparam int NREGS = 4;
  localparam int RW    = $clog2(NREGS);
  localparam int DEPTH = 2;

  typedef logic [RW-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t        idx;
    logic [DW-1:0]   val;
  } wb_entry_t;

  function automatic logic [NREGS-1:0] reg_bit(
    input reg_idx_t i
  );
    return NREGS'(1) << i;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-requester buffer of pending writebacks.
// Registered head, no fall-through, push ignored when full.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      iCLK_WB,
  input  logic      iRST,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t din_i,
  output wb_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge iCLK_WB or posedge iRST) begin
    if (iRST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/wb_scheduler.sv
// Round-robin writeback arbiter with busy-bit scoreboard.
// Issue stalls on RAW/WAW until the destination is written back.
module wb_scheduler
  import wb_pkg::*;
#(
  parameter int DEPTH = wb_pkg::DEPTH
) (
  input  logic                 iRST,
  input  logic                 iCLK_WB,
  input  logic                 iISSUE_VALID,
  input  logic [RW-1:0]        iISSUE_DST,
  input  logic [RW-1:0]        iISSUE_SRC1,
  input  logic [RW-1:0]        iISSUE_SRC2,
  input  logic                 iISSUE_SRC2_IS_IMM,
  output logic                 oSTALL,
  input  logic [NREQ-1:0]      iREQ_VALID,
  input  logic [NREQ*RW-1:0]   iREQ_IDX,
  input  logic [NREQ*DW-1:0]   iREQ_VAL,
  output logic [NREQ-1:0]      oREQ_READY,
  output logic                 oWB_EN,
  output logic [RW-1:0]        oNEXT_REG_IDX,
  output logic [DW-1:0]        oNEXT_REG_VAL,
  output logic [NREGS-1:0]     oBUSY,
  output logic                 oERR
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_entry_t       din  [NREQ];
  wb_entry_t       head [NREQ];
  logic [NREQ-1:0] full;
  logic [NREQ-1:0] empty;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] pop;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic             en_q, en_d;
  reg_idx_t         idx_q, idx_d;
  logic [DW-1:0]    val_q, val_d;

  logic             gnt;
  logic [PW-1:0]    gnt_idx;
  wb_entry_t        win;
  logic             issue_ok;

  function automatic logic [PW-1:0] rr_idx(
    input logic [PW-1:0] base,
    input int            off
  );
    int k;
    k = int'(base) + off;
    if (k >= NREQ) k = k - NREQ;
    return PW'(k);
  endfunction

  for (genvar r = 0; r < NREQ; r++) begin : g_req
    assign din[r]  = {iREQ_IDX[r*RW +: RW], iREQ_VAL[r*DW +: DW]};
    assign push[r] = iREQ_VALID[r] && !full[r];

    wb_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .iCLK_WB (iCLK_WB),
      .iRST    (iRST),
      .push_i  (push[r]),
      .pop_i   (pop[r]),
      .din_i   (din[r]),
      .dout_o  (head[r]),
      .full_o  (full[r]),
      .empty_o (empty[r])
    );
  end

  assign oREQ_READY = ~full;

  // First non-empty head at or after the pointer wins.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt && !empty[rr_idx(ptr_q, i)]) begin
        gnt     = 1'b1;
        gnt_idx = rr_idx(ptr_q, i);
      end
    end
  end

  assign win = head[gnt_idx];
  assign pop = gnt ? (NREQ'(1) << gnt_idx) : '0;

  assign oSTALL = iISSUE_VALID &&
                  (busy_q[iISSUE_SRC1] ||
                   (!iISSUE_SRC2_IS_IMM && busy_q[iISSUE_SRC2]) ||
                   busy_q[iISSUE_DST]);

  assign issue_ok = iISSUE_VALID && !oSTALL;

  always_comb begin
    ptr_d  = ptr_q;
    busy_d = busy_q;
    err_d  = err_q;
    en_d   = gnt;
    idx_d  = idx_q;
    val_d  = val_q;
    if (gnt) begin
      ptr_d  = rr_idx(gnt_idx, 1);
      idx_d  = win.idx;
      val_d  = win.val;
      busy_d = busy_d & ~reg_bit(win.idx);
      if (!busy_q[win.idx]) err_d = 1'b1;
    end
    // Applied after the clear so a same-cycle set wins.
    if (issue_ok) busy_d = busy_d | reg_bit(iISSUE_DST);
  end

  always_ff @(posedge iCLK_WB or posedge iRST) begin
    if (iRST) begin
      ptr_q  <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
      en_q   <= 1'b0;
      idx_q  <= '0;
      val_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      en_q   <= en_d;
      idx_q  <= idx_d;
      val_q  <= val_d;
    end
  end

  assign oWB_EN        = en_q;
  assign oNEXT_REG_IDX = idx_q;
  assign oNEXT_REG_VAL = val_q;
  assign oBUSY         = busy_q;
  assign oERR          = err_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Testbench for wb_scheduler: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_wb_scheduler;
  import wb_pkg::*;

  logic        iRST;
  logic        iCLK_WB;
  logic        iISSUE_VALID;
  logic [1:0]  iISSUE_DST;
  logic [1:0]  iISSUE_SRC1;
  logic [1:0]  iISSUE_SRC2;
  logic        iISSUE_SRC2_IS_IMM;
  logic        oSTALL;
  logic [1:0]  iREQ_VALID;
  logic [3:0]  iREQ_IDX;
  logic [15:0] iREQ_VAL;
  logic [1:0]  oREQ_READY;
  logic        oWB_EN;
  logic [1:0]  oNEXT_REG_IDX;
  logic [7:0]  oNEXT_REG_VAL;
  logic [3:0]  oBUSY;
  logic        oERR;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int val;
  } ent_t;

  ent_t       mq0[$];
  ent_t       mq1[$];
  int         mrr;
  logic [3:0] mbusy;
  logic       merr;
  logic       men;
  logic [1:0] midx;
  logic [7:0] mval;

  wb_scheduler dut (
    .iRST               (iRST),
    .iCLK_WB            (iCLK_WB),
    .iISSUE_VALID       (iISSUE_VALID),
    .iISSUE_DST         (iISSUE_DST),
    .iISSUE_SRC1        (iISSUE_SRC1),
    .iISSUE_SRC2        (iISSUE_SRC2),
    .iISSUE_SRC2_IS_IMM (iISSUE_SRC2_IS_IMM),
    .oSTALL             (oSTALL),
    .iREQ_VALID         (iREQ_VALID),
    .iREQ_IDX           (iREQ_IDX),
    .iREQ_VAL           (iREQ_VAL),
    .oREQ_READY         (oREQ_READY),
    .oWB_EN             (oWB_EN),
    .oNEXT_REG_IDX      (oNEXT_REG_IDX),
    .oNEXT_REG_VAL      (oNEXT_REG_VAL),
    .oBUSY              (oBUSY),
    .oERR               (oERR)
  );

  initial iCLK_WB = 1'b0;
  always #5 iCLK_WB = ~iCLK_WB;

  function automatic logic mstall();
    return iISSUE_VALID &&
           (mbusy[iISSUE_SRC1] ||
            (!iISSUE_SRC2_IS_IMM && mbusy[iISSUE_SRC2]) ||
            mbusy[iISSUE_DST]);
  endfunction

  function automatic logic [1:0] mready();
    logic [1:0] r;
    r[0] = mq0.size() < DEPTH;
    r[1] = mq1.size() < DEPTH;
    return r;
  endfunction

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    mrr   = 0;
    mbusy = '0;
    merr  = 1'b0;
    men   = 1'b0;
    midx  = '0;
    mval  = '0;
  endtask

  task automatic idle();
    iISSUE_VALID       = 1'b0;
    iISSUE_DST         = '0;
    iISSUE_SRC1        = '0;
    iISSUE_SRC2        = '0;
    iISSUE_SRC2_IS_IMM = 1'b0;
    iREQ_VALID         = '0;
    iREQ_IDX           = '0;
    iREQ_VAL           = '0;
  endtask

  task automatic drive_req(input int r, input logic v,
                           input logic [1:0] idx,
                           input logic [7:0] val);
    iREQ_VALID[r]        = v;
    iREQ_IDX[r*2 +: 2]   = idx;
    iREQ_VAL[r*8 +: 8]   = val;
  endtask

  task automatic drive_issue(input logic v, input logic [1:0] dst,
                             input logic [1:0] s1, input logic [1:0] s2,
                             input logic imm);
    iISSUE_VALID       = v;
    iISSUE_DST         = dst;
    iISSUE_SRC1        = s1;
    iISSUE_SRC2        = s2;
    iISSUE_SRC2_IS_IMM = imm;
  endtask

  // One clock edge: the model consumes the inputs seen at the edge.
  task automatic tick();
    ent_t       e;
    int         g;
    logic [1:0] rd;
    logic       st;
    logic [3:0] nb;
    @(posedge iCLK_WB);
    rd = mready();
    st = mstall();
    g  = -1;
    if (mrr == 0)
      g = (mq0.size() > 0) ? 0 : ((mq1.size() > 0) ? 1 : -1);
    else
      g = (mq1.size() > 0) ? 1 : ((mq0.size() > 0) ? 0 : -1);
    nb  = mbusy;
    men = 1'b0;
    if (g >= 0) begin
      if (g == 0) e = mq0.pop_front();
      else        e = mq1.pop_front();
      men  = 1'b1;
      midx = 2'(e.idx);
      mval = 8'(e.val);
      if (!mbusy[midx]) merr = 1'b1;
      nb[midx] = 1'b0;
      mrr = (g + 1) % 2;
    end
    if (iISSUE_VALID && !st) nb[iISSUE_DST] = 1'b1;
    mbusy = nb;
    if (iREQ_VALID[0] && rd[0])
      mq0.push_back('{idx: int'(iREQ_IDX[1:0]), val: int'(iREQ_VAL[7:0])});
    if (iREQ_VALID[1] && rd[1])
      mq1.push_back('{idx: int'(iREQ_IDX[3:2]), val: int'(iREQ_VAL[15:8])});
    #1;
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    idle();
    repeat (2) @(posedge iCLK_WB);
    @(negedge iCLK_WB);
    model_reset();
    iRST = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    idle();
    repeat (2) @(posedge iCLK_WB);
    #1;
    checks++;
    if ({oWB_EN, oNEXT_REG_IDX, oNEXT_REG_VAL, oBUSY, oERR, oSTALL} !== 17'b0) begin
      errors++;
      $display("FAIL reset_outs got %b want 0",
               {oWB_EN, oNEXT_REG_IDX, oNEXT_REG_VAL, oBUSY, oERR, oSTALL});
    end
    checks++;
    if (oREQ_READY !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready got %b want 11", oREQ_READY);
    end
    @(negedge iCLK_WB);
    model_reset();
    iRST = 1'b0;
  endtask

  task automatic test_issue_and_writeback();
    do_reset();
    drive_issue(1'b1, 2'd1, 2'd0, 2'd0, 1'b1);
    #1;
    checks++;
    if (oSTALL !== 1'b0) begin
      errors++;
      $display("FAIL issue_nostall got %b want 0", oSTALL);
    end
    tick();
    checks++;
    if (oBUSY !== 4'b0010 || oBUSY !== mbusy) begin
      errors++;
      $display("FAIL issue_busy got %b want 0010", oBUSY);
    end
    drive_issue(1'b1, 2'd2, 2'd1, 2'd0, 1'b1);
    drive_req(0, 1'b1, 2'd1, 8'd42);
    #1;
    checks++;
    if (oSTALL !== 1'b1) begin
      errors++;
      $display("FAIL raw_stall got %b want 1", oSTALL);
    end
    tick();
    checks++;
    if (oWB_EN !== 1'b0) begin
      errors++;
      $display("FAIL no_fallthru got %b want 0", oWB_EN);
    end
    drive_req(0, 1'b0, 2'd0, 8'd0);
    #1;
    checks++;
    if (oSTALL !== 1'b1) begin
      errors++;
      $display("FAIL stall_during_clear got %b want 1", oSTALL);
    end
    tick();
    checks++;
    if ({oWB_EN, oNEXT_REG_IDX, oNEXT_REG_VAL, oBUSY} !== {1'b1, 2'd1, 8'd42, 4'b0000}) begin
      errors++;
      $display("FAIL wb_first got en=%b idx=%0d val=%0d busy=%b want 1/1/42/0000",
               oWB_EN, oNEXT_REG_IDX, oNEXT_REG_VAL, oBUSY);
    end
    #1;
    checks++;
    if (oSTALL !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got %b want 0", oSTALL);
    end
    tick();
    checks++;
    if (oBUSY !== 4'b0100 || oWB_EN !== 1'b0 || oNEXT_REG_VAL !== 8'd42) begin
      errors++;
      $display("FAIL issue_after got busy=%b en=%b val=%0d want 0100/0/42",
               oBUSY, oWB_EN, oNEXT_REG_VAL);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_val [4];
    exp_val[0] = 8'd10;
    exp_val[1] = 8'd20;
    exp_val[2] = 8'd11;
    exp_val[3] = 8'd21;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_issue(1'b1, 2'(k), 2'(k), 2'(k), 1'b1);
      tick();
    end
    idle();
    checks++;
    if (oBUSY !== 4'b1111) begin
      errors++;
      $display("FAIL b2b_busy got %b want 1111", oBUSY);
    end
    drive_req(0, 1'b1, 2'd0, 8'd10);
    drive_req(1, 1'b1, 2'd1, 8'd20);
    tick();
    drive_req(0, 1'b1, 2'd2, 8'd11);
    drive_req(1, 1'b1, 2'd3, 8'd21);
    #1;
    checks++;
    if (oREQ_READY !== 2'b11) begin
      errors++;
      $display("FAIL b2b_ready1 got %b want 11", oREQ_READY);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      idle();
      checks++;
      if (oWB_EN !== 1'b1 || oNEXT_REG_VAL !== exp_val[k]) begin
        errors++;
        $display("FAIL b2b_grant%0d got en=%b val=%0d want 1/%0d",
                 k, oWB_EN, oNEXT_REG_VAL, exp_val[k]);
      end
      if (k == 0) begin
        #1;
        checks++;
        if (oREQ_READY !== 2'b01 || oREQ_READY !== mready()) begin
          errors++;
          $display("FAIL b2b_full got %b want 01", oREQ_READY);
        end
      end
    end
    tick();
    checks++;
    if (oWB_EN !== 1'b0 || oBUSY !== 4'b0000 || oERR !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got en=%b busy=%b err=%b want 0/0000/0",
               oWB_EN, oBUSY, oERR);
    end
  endtask

  task automatic test_random_traffic();
    logic [1:0] rd;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rd = mready();
      for (int r = 0; r < 2; r++) begin
        if (!(iREQ_VALID[r] && !rd[r]))
          drive_req(r, ($urandom_range(99) < ((r == 1) ? 85 : 45)),
                    2'($urandom), 8'($urandom));
      end
      drive_issue(1'($urandom), 2'($urandom), 2'($urandom),
                  2'($urandom), 1'($urandom));
      #1;
      checks++;
      if (oSTALL !== mstall() || oREQ_READY !== mready()) begin
        errors++;
        $display("FAIL rnd_comb c=%0d got stall=%b rdy=%b want %b/%b",
                 c, oSTALL, oREQ_READY, mstall(), mready());
      end
      tick();
      checks++;
      if (oWB_EN !== men || oNEXT_REG_IDX !== midx ||
          oNEXT_REG_VAL !== mval || oBUSY !== mbusy || oERR !== merr) begin
        errors++;
        $display("FAIL rnd_wb c=%0d got %b/%0d/%0d/%b/%b want %b/%0d/%0d/%b/%b",
                 c, oWB_EN, oNEXT_REG_IDX, oNEXT_REG_VAL, oBUSY, oERR,
                 men, midx, mval, mbusy, merr);
      end
    end
    idle();
  endtask

  task automatic test_err_sticky();
    do_reset();
    drive_req(0, 1'b1, 2'd2, 8'h55);
    tick();
    idle();
    tick();
    checks++;
    if (oWB_EN !== 1'b1 || oNEXT_REG_IDX !== 2'd2 || oERR !== 1'b1) begin
      errors++;
      $display("FAIL err_set got en=%b idx=%0d err=%b want 1/2/1",
               oWB_EN, oNEXT_REG_IDX, oERR);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (oERR !== 1'b1) begin
        errors++;
        $display("FAIL err_hold%0d got %b want 1", k, oERR);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_issue(1'b1, 2'd0, 2'd2, 2'd2, 1'b1);
    tick();
    drive_issue(1'b1, 2'd1, 2'd2, 2'd2, 1'b1);
    tick();
    drive_issue(1'b1, 2'd3, 2'd2, 2'd2, 1'b1);
    tick();
    idle();
    drive_req(0, 1'b1, 2'd2, 8'h31);
    drive_req(1, 1'b1, 2'd2, 8'h41);
    tick();
    drive_req(0, 1'b1, 2'd2, 8'h32);
    drive_req(1, 1'b1, 2'd2, 8'h42);
    tick();
    idle();
    checks++;
    if (oBUSY !== 4'b1011 || (mq0.size() + mq1.size()) != 3) begin
      errors++;
      $display("FAIL mid_pre got busy=%b want 1011", oBUSY);
    end
    #2;
    iRST = 1'b1;
    #1;
    checks++;
    if ({oWB_EN, oNEXT_REG_IDX, oNEXT_REG_VAL, oBUSY, oERR} !== 16'b0 ||
        oREQ_READY !== 2'b11) begin
      errors++;
      $display("FAIL mid_reset got %b rdy=%b want 0/11",
               {oWB_EN, oNEXT_REG_IDX, oNEXT_REG_VAL, oBUSY, oERR}, oREQ_READY);
    end
    model_reset();
    @(negedge iCLK_WB);
    iRST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (oWB_EN !== 1'b0 || oBUSY !== 4'b0000) begin
        errors++;
        $display("FAIL mid_after%0d got en=%b busy=%b want 0/0000",
                 k, oWB_EN, oBUSY);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_issue_and_writeback();
    test_back_to_back();
    test_random_traffic();
    test_err_sticky();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
